// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: per-channel off/on/blink/event-stretch modes,
// one shared blink phase, synchronised event inputs and a lamp-test override.
module led_status_ctrl #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned BLINK_DIV   = 50_000_000,
  parameter int unsigned STRETCH_CYC = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2*N_CH-1:0] mode_i,
  input  logic [N_CH-1:0]   event_i,
  input  logic              lamp_test_i,
  output logic [N_CH-1:0]   led_o,
  output logic              blink_phase_o
);

  localparam int unsigned PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned SW = $clog2(STRETCH_CYC + 1);

  localparam logic [PW-1:0] PrescMax    = PW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] StretchLoad = SW'(STRETCH_CYC);

  localparam logic [1:0] ModeOff     = 2'b00;
  localparam logic [1:0] ModeOn      = 2'b01;
  localparam logic [1:0] ModeBlink   = 2'b10;
  localparam logic [1:0] ModeStretch = 2'b11;

  logic [PW-1:0]   r_presc;
  logic            r_blink;
  logic [N_CH-1:0] r_s1, r_s2, r_s2_d;
  logic [N_CH-1:0] r_led;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_led_d;
  logic            w_presc_wrap;

  assign w_presc_wrap = (r_presc == PrescMax);
  assign w_rise       = r_s2 & ~r_s2_d;

  // Free-running prescaler; the blink phase is shared by every channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_blink <= 1'b0;
    end else if (w_presc_wrap) begin
      r_presc <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s2_d <= '0;
    end else begin
      r_s1   <= event_i;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]    w_mode;
    logic [SW-1:0] r_cnt;
    logic [SW-1:0] w_cnt_d;
    logic          w_led_bit;

    assign w_mode = mode_i[2*i +: 2];

    // Leaving stretch mode clears the counter, so re-entry needs a fresh rise.
    always_comb begin
      w_cnt_d = r_cnt;
      if (w_mode != ModeStretch) begin
        w_cnt_d = '0;
      end else if (w_rise[i]) begin
        w_cnt_d = StretchLoad;
      end else if (r_cnt != '0) begin
        w_cnt_d = r_cnt - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_d;
      end
    end

    always_comb begin
      w_led_bit = 1'b0;
      if (lamp_test_i) begin
        w_led_bit = 1'b1;
      end else begin
        case (w_mode)
          ModeOff:     w_led_bit = 1'b0;
          ModeOn:      w_led_bit = 1'b1;
          ModeBlink:   w_led_bit = r_blink;
          ModeStretch: w_led_bit = (r_cnt != '0);
          default:     w_led_bit = 1'b0;
        endcase
      end
    end

    assign w_led_d[i] = w_led_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led_d;
    end
  end

  assign led_o         = r_led;
  assign blink_phase_o = r_blink;

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Parametrised multi-channel status-LED driver for board bring-up of the TDC design.
- Successor to the fixed combinational switch-to-LED test logic.
- Each channel has a selectable mode: off, on, blink, or event pulse-stretch.
- Async event inputs are synchronised. All blink channels share one phase. A lamp-test input forces every LED on.

Parameters:
- N_CH, 4, number of LED channels (>=1).
- BLINK_DIV, 50_000_000, clk cycles per blink half-period (>=2); blink period = 2*BLINK_DIV.
- STRETCH_CYC, 10_000_000, clk cycles an LED stays lit after an event (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode_i  in  2*N_CH  per-channel mode; channel i uses bits [2i+1:2i]. 00 off, 01 on, 10 blink, 11 stretch. Synchronous to clk.
- event_i  in  N_CH  per-channel event, asynchronous (switch or pin); rising edge triggers stretch.
- lamp_test_i  in  1  synchronous; forces all led_o high while 1.
- led_o  out  N_CH  registered LED drive, active-high.
- blink_phase_o  out  1  shared blink phase, for debug.

Behaviour:
- Reset (rst_n=0, async assert, sync release by the system):
  - led_o=0, blink_phase_o=0.
  - Prescaler=0, all stretch counters=0.
  - Synchroniser and edge-detect flops=0.
- Prescaler (width clog2(BLINK_DIV)):
  - Counts 0..BLINK_DIV-1 and wraps to 0.
  - blink_phase toggles on the edge where the count equals BLINK_DIV-1.
  - First toggle occurs at the BLINK_DIV-th clk edge after reset release.
  - Runs free regardless of mode.
- Event path, per channel:
  - 2-flop synchroniser (s1, s2), plus s2_d.
  - rise = s2 & ~s2_d.
  - Event high sampled at edge k: s2=1 after edge k+1; rise is seen and the counter is loaded at edge k+2.
- Stretch counter, per channel (width clog2(STRETCH_CYC+1)):
  - If mode!=11: counter forced to 0 at each edge.
  - Else if rise: load STRETCH_CYC. Retrigger while nonzero reloads it, so the output extends and does not toggle.
  - Else if nonzero: decrement.
  - Counter saturates at 0.
- Output register, updated every edge:
  - If lamp_test_i=1: led_o[i] <= 1.
  - Otherwise, by mode: 00 -> 0; 01 -> 1; 10 -> blink_phase (current register value); 11 -> (stretch counter != 0).
- Latencies:
  - Mode or lamp-test change: visible on led_o one edge later.
  - Event: led_o rises at edge k+3 and stays high exactly STRETCH_CYC cycles.
  - Blink: led_o lags blink_phase_o by one cycle. Duty cycle is exactly 50%.
- All blink-mode channels are always in phase with each other.
- Switching a channel into blink takes the current shared phase; the prescaler is not restarted.
- Boundary cases:
  - Event pulse shorter than one clk period may be missed; this is allowed. Pulses of >=2 cycles are guaranteed to be caught.
  - Event held high: one trigger only. A new trigger requires a low of >=2 cycles.
  - Mode change 11->other mid-stretch: counter cleared. Returning to 11 does not relight without a new rise.
  - Rise that coincides with a mode change to 11: the mode in effect at that edge decides. If mode was 11 at the edge, load.
  - lamp_test does not affect counters or the prescaler. Releasing it restores mode behaviour on the next edge.
  - Reset mid-stretch or mid-blink: immediate return to reset values.

Test Plan (N_CH=4, BLINK_DIV=4, STRETCH_CYC=5):
- Reset, then mode_i=8'b00_00_01_00 -> led_o=4'b0010 one edge after mode applied. blink_phase_o toggles at edges 4, 8, 12 after reset release.
- All channels mode 10 -> led_o=4'b1111 and 4'b0000 alternating, 4 cycles each. All bits identical every cycle. led_o lags blink_phase_o by 1 cycle.
- Ch3 mode 11, event_i[3] high 2 cycles at edge k -> led_o[3]=1 from edge k+3 through k+7, then 0.
- Ch3 retrigger: second event 3 cycles after the first rise -> led_o[3] stays high continuously until 5 cycles after the second load.
- Ch3 mid-stretch: mode to 00 -> led_o[3]=0 next edge; mode back to 11 with no event -> stays 0. Separately, event held high 20 cycles -> single 5-cycle pulse.
- lamp_test_i=1 with mixed modes -> led_o=4'b1111 next edge; release -> mode outputs resume next edge. rst_n asserted mid-blink -> led_o=0 and blink_phase_o=0 immediately, without waiting for a clk edge.
